// File: rtl/poly_keyboard_pkg.sv
// Shared types and constants for the polyphonic keyboard front end.
// Holds the note increment table, the scanner state type and the key-to-increment helper.
package poly_keyboard_pkg;

  localparam int SYNTH_PHASE_ACC_BITS = 24;

  typedef logic [SYNTH_PHASE_ACC_BITS-1:0] phase_inc_t;

  // A4 .. Ab5 phase increments for the synth accumulator
  localparam phase_inc_t NOTE_INC [12] = '{
    24'h09630, 24'h09F1E, 24'h0A894, 24'h0B29A,
    24'h0BD3A, 24'h0C87A, 24'h0D465, 24'h0E107,
    24'h0EE69, 24'h0FC63, 24'h10B9A, 24'h11B82
  };

  typedef enum logic [0:0] {
    SCAN  = 1'b0,
    EVENT = 1'b1
  } scan_state_t;

  // octave: 2-bit signed shift, -2..+1; negative values shift right logically
  function automatic phase_inc_t key_to_inc(input logic [4:0] key, input logic [1:0] octave);
    phase_inc_t base;
    logic [3:0] idx;
    if (key >= 5'd12) begin
      idx  = 4'(key - 5'd12);
      base = NOTE_INC[idx] << 1;
    end else begin
      idx  = key[3:0];
      base = NOTE_INC[idx];
    end
    case (octave)
      2'b01:   key_to_inc = base << 1;
      2'b11:   key_to_inc = base >> 1;
      2'b10:   key_to_inc = base >> 2;
      default: key_to_inc = base;
    endcase
  endfunction

endpackage

// File: rtl/poly_keyboard_key_debouncer.sv
// One key: 2-flop synchroniser followed by a stable-level debounce counter.
// The debounced level flips only after DEBOUNCE_CYCLES consecutive differing cycles.
module key_debouncer #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic key_in,
  output logic deb_out
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_deb;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_deb   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= key_in;
      r_sync2 <= r_sync1;
      // any return to the accepted level restarts the count
      if (r_sync2 != r_deb) begin
        if (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          r_deb <= r_sync2;
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign deb_out = r_deb;

endmodule

// File: rtl/poly_keyboard.sv
// Polyphonic keyboard: debounced keys, round-robin scanner and voice allocator with stealing.
// Optional portamento between increments when POLY_KEYBOARD_GLIDE_EN is defined.
module poly_keyboard
  import poly_keyboard_pkg::*;
#(
  parameter int NUM_KEYS        = 13,
  parameter int NUM_VOICES      = 4,
  parameter int DEBOUNCE_CYCLES = 1_000_000
`ifdef POLY_KEYBOARD_GLIDE_EN
  ,
  parameter int GLIDE_SHIFT     = 4,
  parameter int GLIDE_TICK      = 1000
`endif
) (
  input  logic                                             clk_in,
  input  logic                                             rst_in,
  input  logic [NUM_KEYS-1:0]                              key_in,
  input  logic [1:0]                                       octave_in,
  output logic [NUM_VOICES-1:0][SYNTH_PHASE_ACC_BITS-1:0]  phase_inc_out,
  output logic [NUM_VOICES-1:0]                            gate_out,
  output logic [NUM_VOICES-1:0]                            note_on_out,
  output logic                                             steal_out
);

  localparam int KEY_W   = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;
  localparam int VOICE_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

  logic [NUM_KEYS-1:0] w_deb;

  generate
    for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_key
      key_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_deb (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .key_in (key_in[gi]),
        .deb_out(w_deb[gi])
      );
    end
  endgenerate

  scan_state_t         r_state;
  logic [KEY_W-1:0]    r_ptr;
  logic [NUM_KEYS-1:0] r_held;
  logic                r_ev_press;
  logic [KEY_W-1:0]    w_ptr_next;

  assign w_ptr_next = (r_ptr == KEY_W'(NUM_KEYS - 1)) ? '0 : r_ptr + 1'b1;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state    <= SCAN;
      r_ptr      <= '0;
      r_held     <= '0;
      r_ev_press <= 1'b0;
    end else begin
      case (r_state)
        SCAN: begin
          if (w_deb[r_ptr] != r_held[r_ptr]) begin
            r_ev_press <= w_deb[r_ptr];
            r_state    <= EVENT;
          end else begin
            r_ptr <= w_ptr_next;
          end
        end
        default: begin
          r_held[r_ptr] <= r_ev_press;
          r_ptr         <= w_ptr_next;
          r_state       <= SCAN;
        end
      endcase
    end
  end

  logic                   w_ev_press;
  logic                   w_ev_release;
  logic                   w_free_found;
  logic [VOICE_W-1:0]     w_free_idx;
  logic [VOICE_W-1:0]     w_target;
  phase_inc_t             w_new_inc;

  logic [NUM_VOICES-1:0]  r_gate;
  logic [NUM_VOICES-1:0]  r_note_on;
  logic                   r_steal;
  logic [VOICE_W-1:0]     r_steal_ptr;
  logic [KEY_W-1:0]       r_voice_key [NUM_VOICES];
  phase_inc_t             r_inc       [NUM_VOICES];

  assign w_ev_press   = (r_state == EVENT) && r_ev_press;
  assign w_ev_release = (r_state == EVENT) && !r_ev_press;
  assign w_new_inc    = key_to_inc(5'(r_ptr), octave_in);

  // lowest-index idle voice wins; otherwise steal round-robin
  always_comb begin
    w_free_found = 1'b0;
    w_free_idx   = '0;
    for (int v = NUM_VOICES - 1; v >= 0; v--) begin
      if (!r_gate[v]) begin
        w_free_found = 1'b1;
        w_free_idx   = VOICE_W'(v);
      end
    end
    w_target = w_free_found ? w_free_idx : r_steal_ptr;
  end

`ifdef POLY_KEYBOARD_GLIDE_EN
  localparam int GT_W = $clog2(GLIDE_TICK + 1);
  localparam int PB   = SYNTH_PHASE_ACC_BITS;

  logic [GT_W-1:0]    r_glide_cnt;
  logic               w_glide_tick;
  phase_inc_t         r_target [NUM_VOICES];
  logic signed [PB:0] w_diff   [NUM_VOICES];
  logic signed [PB:0] w_step   [NUM_VOICES];

  assign w_glide_tick = (r_glide_cnt == GT_W'(GLIDE_TICK - 1));

  always_ff @(posedge clk_in) begin
    if (rst_in || w_glide_tick) begin
      r_glide_cnt <= '0;
    end else begin
      r_glide_cnt <= r_glide_cnt + 1'b1;
    end
  end

  // step is a fraction of the remaining distance, never smaller than one LSB
  always_comb begin
    for (int v = 0; v < NUM_VOICES; v++) begin
      w_diff[v] = $signed({1'b0, r_target[v]}) - $signed({1'b0, r_inc[v]});
      w_step[v] = w_diff[v] >>> GLIDE_SHIFT;
      if ((w_step[v] == '0) && (w_diff[v] != '0)) begin
        w_step[v] = w_diff[v][PB] ? '1 : (PB + 1)'(1);
      end
    end
  end
`endif

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_gate      <= '0;
      r_note_on   <= '0;
      r_steal     <= 1'b0;
      r_steal_ptr <= '0;
      for (int v = 0; v < NUM_VOICES; v++) begin
        r_voice_key[v] <= '0;
        r_inc[v]       <= '0;
`ifdef POLY_KEYBOARD_GLIDE_EN
        r_target[v]    <= '0;
`endif
      end
    end else begin
      r_note_on <= '0;
      r_steal   <= 1'b0;
`ifdef POLY_KEYBOARD_GLIDE_EN
      if (w_glide_tick) begin
        for (int v = 0; v < NUM_VOICES; v++) begin
          r_inc[v] <= r_inc[v] + w_step[v][PB-1:0];
        end
      end
`endif
      if (w_ev_press) begin
        r_gate[w_target]      <= 1'b1;
        r_voice_key[w_target] <= r_ptr;
        r_note_on[w_target]   <= 1'b1;
`ifdef POLY_KEYBOARD_GLIDE_EN
        r_target[w_target] <= w_new_inc;
        // a silent, never-tuned voice has nothing to glide from
        if (!r_gate[w_target] && (r_inc[w_target] == '0)) begin
          r_inc[w_target] <= w_new_inc;
        end
`else
        r_inc[w_target] <= w_new_inc;
`endif
        if (!w_free_found) begin
          r_steal     <= 1'b1;
          r_steal_ptr <= (r_steal_ptr == VOICE_W'(NUM_VOICES - 1)) ? '0 : r_steal_ptr + 1'b1;
        end
      end
      // increment is left alone on release so the envelope tail keeps its pitch
      if (w_ev_release) begin
        for (int v = 0; v < NUM_VOICES; v++) begin
          if (r_gate[v] && (r_voice_key[v] == r_ptr)) begin
            r_gate[v] <= 1'b0;
          end
        end
      end
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_VOICES; gi++) begin : g_out
      assign phase_inc_out[gi] = r_inc[gi];
    end
  endgenerate

  assign gate_out    = r_gate;
  assign note_on_out = r_note_on;
  assign steal_out   = r_steal;

endmodule
